// File: rtl/dbg_capture_pkg.sv
// Shared types and constants for the multi-channel debug capture bank.
package dbg_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FILL,
        ST_DONE
    } state_e;

    localparam bit MODE_POST = 1'b0;
    localparam bit MODE_PRE  = 1'b1;

endpackage

// File: rtl/dbg_capture_channel.sv
// One capture channel: edge detectors, capture FSM, pointers and sample RAM.
module dbg_capture_channel
    import dbg_capture_pkg::*;
#(
    parameter int W        = 24,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         capture_i,
    input  logic         next_i,
    output logic [W-1:0] data_o,
    output logic         done_o
);

    localparam int PW = $clog2(DEPTH);
    localparam bit IS_PRE = (PRE_TRIG != 0) ? MODE_PRE : MODE_POST;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] HALF = PW'(DEPTH / 2);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam state_e RST_ST = (IS_PRE == MODE_PRE) ? ST_ARMED : ST_IDLE;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          cap_q, nxt_q;
    logic          cap_edge, nxt_edge;
    logic          we;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  data_q;

    assign cap_edge = capture_i & ~cap_q;
    assign nxt_edge = next_i & ~nxt_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        if (IS_PRE == MODE_PRE) begin
            unique case (state_q)
                ST_IDLE, ST_ARMED: begin
                    if (valid_i) begin
                        we   = 1'b1;
                        wr_d = wr_q + ONE;
                    end
                    if (cap_edge) begin
                        cnt_d   = HALF;
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (valid_i) begin
                        we   = 1'b1;
                        wr_d = wr_q + ONE;
                    end
                    // A new trigger mid-fill restarts the post-trigger window
                    if (cap_edge) begin
                        cnt_d = HALF;
                    end else if (valid_i) begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            state_d = ST_DONE;
                            rd_d    = wr_q + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (cap_edge) begin
                        state_d = ST_ARMED;
                    end else if (nxt_edge) begin
                        rd_d = rd_q + ONE;
                    end
                end
            endcase
        end else begin
            if (cap_edge) begin
                wr_d    = '0;
                rd_d    = '0;
                state_d = ST_FILL;
            end else begin
                unique case (state_q)
                    ST_FILL: begin
                        if (valid_i) begin
                            we   = 1'b1;
                            wr_d = wr_q + ONE;
                            if (wr_q == LAST) state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (nxt_edge) rd_d = rd_q + ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_ST;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            nxt_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            cap_q   <= capture_i;
            nxt_q   <= next_i;
            data_q  <= mem_q[rd_q];
        end
    end

    // RAM has no reset so contents survive an aborted capture
    always_ff @(posedge clk_i) begin
        if (we) mem_q[wr_q] <= data_i;
    end

    assign data_o = data_q;
    assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/dbg_capture_bank.sv
// Bank of independent debug capture channels sharing one clock and reset.
module dbg_capture_bank
    import dbg_capture_pkg::*;
#(
    parameter int N_CH     = 9,
    parameter int W        = 24,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   sample_valid,
    input  logic [N_CH*W-1:0] sample_data,
    input  logic [N_CH-1:0]   dbg_capture,
    input  logic [N_CH-1:0]   dbg_next,
    output logic [N_CH*W-1:0] dbg_data,
    output logic [N_CH-1:0]   dbg_done
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dbg_capture_channel #(
            .W        (W),
            .DEPTH    (DEPTH),
            .PRE_TRIG (PRE_TRIG)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (reset_n),
            .valid_i   (sample_valid[c]),
            .data_i    (sample_data[c*W +: W]),
            .capture_i (dbg_capture[c]),
            .next_i    (dbg_next[c]),
            .data_o    (dbg_data[c*W +: W]),
            .done_o    (dbg_done[c])
        );
    end

endmodule

// File: tb/tb_dbg_capture_bank.sv
// Directed scoreboard bench for post- and pre-trigger capture banks.
module tb_dbg_capture_bank;

    localparam int W = 24;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]     p_valid, p_cap, p_next, p_done;
    logic [2*W-1:0] p_data, p_dout;
    logic [0:0]     q_valid, q_cap, q_next, q_done;
    logic [W-1:0]   q_data, q_dout;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] pm [D];
    int prd;

    dbg_capture_bank #(.N_CH(2), .W(W), .DEPTH(D), .PRE_TRIG(0)) u_post (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (p_valid),
        .sample_data  (p_data),
        .dbg_capture  (p_cap),
        .dbg_next     (p_next),
        .dbg_data     (p_dout),
        .dbg_done     (p_done)
    );

    dbg_capture_bank #(.N_CH(1), .W(W), .DEPTH(D), .PRE_TRIG(1)) u_pre (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (q_valid),
        .sample_data  (q_data),
        .dbg_capture  (q_cap),
        .dbg_next     (q_next),
        .dbg_data     (q_dout),
        .dbg_done     (q_done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [W-1:0] obs);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <empty scoreboard>", tag, obs);
        end else begin
            check(tag, obs, sb.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p_read(input string tag);
        prd = (prd + 1) % D;
        sb.push_back(pm[prd]);
        p_next = 2'b01;
        step();
        p_next = 2'b00;
        step();
        pop_check(tag, p_dout[W-1:0]);
    endtask

    task automatic p_fill(input int base, input string tag);
        for (int k = 1; k <= D; k++) begin
            p_valid = 2'b01;
            p_data  = {24'h0, 24'(base + k)};
            pm[k-1] = 24'(base + k);
            step();
            check(tag, {23'b0, p_done[0]}, {23'b0, k == D});
        end
        p_valid = 2'b00;
        prd = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        p_valid = '0; p_cap = '0; p_next = '0; p_data = '0;
        q_valid = '0; q_cap = '0; q_next = '0; q_data = '0;
        repeat (3) step();
        check("rst_p_done", {22'b0, p_done}, 24'h0);
        check("rst_p_dout", p_dout[W-1:0], 24'h0);
        check("rst_q_done", {23'b0, q_done}, 24'h0);
        check("rst_q_dout", q_dout, 24'h0);
        reset_n = 1'b1;
        step();

        // Capture edge with a same-cycle sample that must be dropped
        p_cap   = 2'b01;
        p_valid = 2'b01;
        p_data  = {24'h0, 24'hAAAAAA};
        step();
        p_fill(0, "post_done");
        for (int k = 9; k <= 10; k++) begin
            p_valid = 2'b01;
            p_data  = {24'h0, 24'(k)};
            step();
        end
        p_valid = 2'b00;
        step();
        step();
        sb.push_back(pm[0]);
        pop_check("post_rd0", p_dout[W-1:0]);

        prd = 1;
        sb.push_back(pm[1]);
        p_next = 2'b01;
        step();
        check("lat_t1", p_dout[W-1:0], pm[0]);
        p_next = 2'b00;
        step();
        pop_check("lat_t2", p_dout[W-1:0]);
        for (int i = 0; i < 7; i++) p_read("post_rd");

        p_next = 2'b01;
        repeat (5) step();
        p_next = 2'b00;
        step();
        check("hold_next", p_dout[W-1:0], pm[1]);
        check("ch1_done", {23'b0, p_done[1]}, 24'h0);

        // Capture and next together in DONE: capture wins
        p_cap = 2'b00;
        step();
        p_cap  = 2'b01;
        p_next = 2'b01;
        step();
        check("cap_next_done", {23'b0, p_done[0]}, 24'h0);
        p_next = 2'b00;
        p_fill(100, "refill_done");
        step();
        step();
        check("cap_wins_rd0", p_dout[W-1:0], 24'd101);

        // Asynchronous reset in the middle of a fill
        p_cap = 2'b00;
        step();
        p_cap = 2'b01;
        step();
        for (int k = 1; k <= 3; k++) begin
            p_valid = 2'b01;
            p_data  = {24'h0, 24'(200 + k)};
            step();
        end
        p_valid = 2'b00;
        p_cap   = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_done", {23'b0, p_done[0]}, 24'h0);
        check("midrst_dout", p_dout[W-1:0], 24'h0);
        step();
        step();
        reset_n = 1'b1;
        step();
        p_cap = 2'b01;
        step();
        p_fill(300, "fresh_done");
        step();
        step();
        check("fresh_rd0", p_dout[W-1:0], 24'd301);
        p_read("fresh_rd");
        p_read("fresh_rd");
        p_cap = 2'b00;

        // Pre-trigger: edge registers with sample 12
        for (int i = 1; i <= 20; i++) begin
            q_valid = 1'b1;
            q_data  = 24'(i);
            q_cap   = (i >= 12) ? 1'b1 : 1'b0;
            step();
            if (i == 15) check("pre_done15", {23'b0, q_done}, 24'h0);
            if (i == 16) check("pre_done16", {23'b0, q_done}, 24'h1);
        end
        q_valid = 1'b0;
        for (int k = 0; k < D; k++) sb.push_back(24'(12 - D/2 + 1 + k));
        sb.push_back(24'(12 - D/2 + 1));
        step();
        step();
        pop_check("pre_rd", q_dout);
        for (int k = 0; k < D; k++) begin
            q_next = 1'b1;
            step();
            q_next = 1'b0;
            step();
            pop_check("pre_rd", q_dout);
        end
        check("pre_done_end", {23'b0, q_done}, 24'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
